// File: rtl/mdu_pkg.sv
// Shared constants and enums for the decode/execute stage with its iterative multiply/divide unit.
// The DIV state is only present when MDU_DIV_EN is defined.
package mdu_pkg;

  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [6:0]  F7_MULDIV = 7'b0000001;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Encoded exactly as funct3 so the instruction field casts straight in.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
`ifdef MDU_DIV_EN
    ,
    ST_DIV  = 2'd3
`endif
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 shift-add multiplier and (with MDU_DIV_EN) restoring divider.
// Operates on magnitudes for XLEN cycles and fixes the sign up when the result is read.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  mdu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);

  logic              run;
  logic [CW-1:0]     cnt;
  mdu_op_e           op_q;
  logic              neg_q;
  logic              a_signed, b_signed, a_neg, b_neg, dbz;
  logic [XLEN-1:0]   a_abs, b_abs, mplier, mul_res;
  logic [2*XLEN-1:0] acc, mcand, prod;

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && a[XLEN-1];
    b_neg    = b_signed && b[XLEN-1];
    a_abs    = a_neg ? -a : a;
    b_abs    = b_neg ? -b : b;
    prod     = neg_q ? -acc : acc;
    mul_res  = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef MDU_DIV_EN
  logic            dbz_q, a_neg_q, is_div_q;
  logic [XLEN-1:0] quo, rem, dvs, dividend_q, quot_res, rem_res;
  logic [XLEN:0]   shifted, trial;

  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    trial    = shifted - {1'b0, dvs};
    quot_res = dbz_q ? '1 : (neg_q ? -quo : quo);
    rem_res  = dbz_q ? dividend_q : (a_neg_q ? -rem : rem);
    is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_REM) || (op_q == OP_REMU);
    if (!is_div_q) result = mul_res;
    else if ((op_q == OP_REM) || (op_q == OP_REMU)) result = rem_res;
    else result = quot_res;
  end
  assign dbz = dbz_q;
`else
  assign dbz    = 1'b0;
  assign result = mul_res;
`endif

  // Divide by zero finishes after its first cycle; everything else runs XLEN steps.
  assign done = run && ((cnt == CW'(XLEN - 1)) || dbz);

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      op_q   <= op;
      neg_q  <= a_neg ^ b_neg;
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, a_abs};
      mplier <= b_abs;
`ifdef MDU_DIV_EN
      a_neg_q    <= a_neg;
      dbz_q      <= op[2] && (b == '0);
      dividend_q <= a;
      quo        <= a_abs;
      rem        <= '0;
      dvs        <= b_abs;
`endif
    end else if (run) begin
      cnt    <= cnt + CW'(1);
      if (done) run <= 1'b0;
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
`ifdef MDU_DIV_EN
      if (!trial[XLEN]) begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
`endif
    end
  end

endmodule

// File: rtl/decode_exec_mdu.sv
// Decode/execute stage: operand forwarding, M-extension control FSM and pipeline registers.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU/REM/REMU complete at once as illegal.
module decode_exec_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          stall_in,
  input  logic                          valid_in,
  input  logic [31:0]                   instruction,
  input  logic [XLEN-1:0]               pc,
  input  logic [XLEN-1:0]               rdata1,
  input  logic [XLEN-1:0]               rdata2,
  input  logic [XLEN-1:0]               alu_res,
  input  logic [$clog2(NUM_FWD+1)-1:0]  fwd_sel_a,
  input  logic [$clog2(NUM_FWD+1)-1:0]  fwd_sel_b,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
  output logic                          busy,
  output logic                          valid_ppl,
  output logic                          ill_ppl,
  output logic [XLEN-1:0]               result_ppl,
  output logic [XLEN-1:0]               rdata2_ppl,
  output logic [XLEN-1:0]               pc_ppl,
  output logic [31:0]                   instruction_ppl,
  output mdu_state_e                    fsm_state
);
  localparam int SW = $clog2(NUM_FWD + 1);

  mdu_state_e      state;
  mdu_op_e         m_op;
  logic [XLEN-1:0] op_a, op_b, iter_result, m_pc, m_rs2;
  logic [31:0]     m_instr;
  logic            is_m, is_div, ill_op, accept, iter_done;

  always_comb begin
    op_a = rdata1;
    op_b = rdata2;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (fwd_sel_a == SW'(k)) op_a = fwd_data[(k-1)*XLEN +: XLEN];
      if (fwd_sel_b == SW'(k)) op_b = fwd_data[(k-1)*XLEN +: XLEN];
    end
  end

  assign is_m   = (instruction[6:0] == OPC_OP) && (instruction[31:25] == F7_MULDIV);
  assign is_div = instruction[14];
  assign m_op   = mdu_op_e'(instruction[14:12]);
`ifdef MDU_DIV_EN
  assign ill_op = 1'b0;
`else
  assign ill_op = is_m && is_div;
`endif

  // Handshake: busy is the upstream stall. An instruction with valid_in high is consumed at the
  // next edge when busy and stall_in are both low; busy rises combinationally as an M-op is taken.
  assign accept    = (state == ST_IDLE) && valid_in && is_m && !ill_op && !stall_in && !flush && !rst;
  assign busy      = accept || (state != ST_IDLE);
  assign fsm_state = state;

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .abort  (flush),
    .start  (accept),
    .op     (m_op),
    .a      (op_a),
    .b      (op_b),
    .done   (iter_done),
    .result (iter_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      valid_ppl       <= 1'b0;
      ill_ppl         <= 1'b0;
      result_ppl      <= '0;
      rdata2_ppl      <= '0;
      pc_ppl          <= '0;
      instruction_ppl <= NOP_INSTR;
    end else if (flush) begin
      state           <= ST_IDLE;
      valid_ppl       <= 1'b0;
      ill_ppl         <= 1'b0;
      instruction_ppl <= NOP_INSTR;
    end else begin
      case (state)
        ST_IDLE: if (!stall_in) begin
          if (accept) begin
`ifdef MDU_DIV_EN
            state <= is_div ? ST_DIV : ST_MUL;
`else
            state <= ST_MUL;
`endif
            valid_ppl <= 1'b0;
            m_instr   <= instruction;
            m_pc      <= pc;
            m_rs2     <= op_b;
          end else if (valid_in) begin
            valid_ppl       <= 1'b1;
            ill_ppl         <= ill_op;
            result_ppl      <= ill_op ? '0 : alu_res;
            pc_ppl          <= pc;
            instruction_ppl <= instruction;
            rdata2_ppl      <= op_b;
          end else begin
            valid_ppl <= 1'b0;
          end
        end
        ST_MUL: if (iter_done) state <= ST_DONE;
`ifdef MDU_DIV_EN
        ST_DIV: if (iter_done) state <= ST_DONE;
`endif
        ST_DONE: if (!stall_in) begin
          state           <= ST_IDLE;
          valid_ppl       <= 1'b1;
          ill_ppl         <= 1'b0;
          result_ppl      <= iter_result;
          pc_ppl          <= m_pc;
          instruction_ppl <= m_instr;
          rdata2_ppl      <= m_rs2;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_exec_mdu.sv
// Directed bench for decode_exec_mdu; the divide checks follow the MDU_DIV_EN build setting.
module tb_decode_exec_mdu;
  import mdu_pkg::*;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int SW      = $clog2(NUM_FWD + 1);
  localparam logic [31:0] ADDI_X3 = {12'd5, 5'd1, 3'b000, 5'd3, 7'b0010011};
  localparam logic [31:0] ADD_X3  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

  logic                    clk = 1'b0;
  logic                    rst, flush, stall_in, valid_in;
  logic [31:0]             instruction;
  logic [XLEN-1:0]         pc, rdata1, rdata2, alu_res;
  logic [SW-1:0]           fwd_sel_a, fwd_sel_b;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    busy, valid_ppl, ill_ppl;
  logic [XLEN-1:0]         result_ppl, rdata2_ppl, pc_ppl;
  logic [31:0]             instruction_ppl;
  mdu_state_e              fsm_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [XLEN-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  decode_exec_mdu #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .valid_in(valid_in),
    .instruction(instruction), .pc(pc), .rdata1(rdata1), .rdata2(rdata2), .alu_res(alu_res),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_data(fwd_data),
    .busy(busy), .valid_ppl(valid_ppl), .ill_ppl(ill_ppl), .result_ppl(result_ppl),
    .rdata2_ppl(rdata2_ppl), .pc_ppl(pc_ppl), .instruction_ppl(instruction_ppl),
    .fsm_state(fsm_state)
  );

  function automatic logic [31:0] mdu_instr(input logic [2:0] f3);
    return {F7_MULDIV, 5'd2, 5'd1, f3, 5'd3, OPC_OP};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; stall_in = 1'b0; valid_in = 1'b0;
    instruction = NOP_INSTR; pc = '0; rdata1 = '0; rdata2 = '0; alu_res = '0;
    fwd_sel_a = '0; fwd_sel_b = '0; fwd_data = '0;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc_v, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] alu, input logic [SW-1:0] sel_a);
    int idx;
    instruction = instr; pc = pc_v; rdata2 = b; alu_res = alu;
    fwd_sel_a = sel_a; fwd_sel_b = '0; valid_in = 1'b1;
    if (sel_a == '0) begin
      rdata1 = a;
    end else begin
      rdata1 = 32'hdead_beef;
      idx = int'(sel_a) - 1;
      fwd_data[idx*XLEN +: XLEN] = a;
    end
  endtask

  // Issues an M-op and waits (bounded) for valid_ppl; reports latency and cycles with busy high.
  task automatic run_op(input logic [31:0] instr, input logic [31:0] pc_v, input logic [31:0] a,
                        input logic [31:0] b, input logic [SW-1:0] sel_a,
                        output int lat, output int bcy);
    bit got;
    drive(instr, pc_v, a, b, 32'h0, sel_a);
    lat = 0; bcy = 0; got = 0;
    while (lat < 60 && !got) begin
      #1;
      if (busy) bcy++;
      tick();
      lat++;
      valid_in = 1'b0;
      if (valid_ppl) got = 1;
    end
  endtask

  // tests
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy got %b want 0", busy); end
    vec_cnt++; if (valid_ppl !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %b want 0", valid_ppl); end
    vec_cnt++; if (ill_ppl !== 1'b0) begin err_cnt++; $display("FAIL rst_ill got %b want 0", ill_ppl); end
    vec_cnt++; if (result_ppl !== 32'h0) begin err_cnt++; $display("FAIL rst_result got %h want 0", result_ppl); end
    vec_cnt++; if (rdata2_ppl !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata2 got %h want 0", rdata2_ppl); end
    vec_cnt++; if (pc_ppl !== 32'h0) begin err_cnt++; $display("FAIL rst_pc got %h want 0", pc_ppl); end
    vec_cnt++; if (instruction_ppl !== 32'h0000_0013) begin err_cnt++; $display("FAIL rst_instr got %h want 00000013", instruction_ppl); end
    vec_cnt++; if (fsm_state !== ST_IDLE) begin err_cnt++; $display("FAIL rst_state got %0d want %0d", fsm_state, ST_IDLE); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    drive(ADDI_X3, 32'h100, 32'h1, 32'h22, 32'h5, 2'd0);
    fwd_sel_b = 2'd2;
    fwd_data[63:32] = 32'h77;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL alu_busy got %b want 0", busy); end
    tick();
    vec_cnt++; if (valid_ppl !== 1'b1) begin err_cnt++; $display("FAIL alu_valid got %b want 1", valid_ppl); end
    vec_cnt++; if (result_ppl !== 32'h5) begin err_cnt++; $display("FAIL alu_result got %h want 5", result_ppl); end
    vec_cnt++; if (pc_ppl !== 32'h100) begin err_cnt++; $display("FAIL alu_pc got %h want 100", pc_ppl); end
    vec_cnt++; if (instruction_ppl !== ADDI_X3) begin err_cnt++; $display("FAIL alu_instr got %h want %h", instruction_ppl, ADDI_X3); end
    vec_cnt++; if (rdata2_ppl !== 32'h77) begin err_cnt++; $display("FAIL alu_fwd_rs2 got %h want 77", rdata2_ppl); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL alu_busy_after got %b want 0", busy); end
    valid_in = 1'b0;
    fwd_sel_b = '0;
    tick();
    vec_cnt++; if (valid_ppl !== 1'b0) begin err_cnt++; $display("FAIL idle_valid got %b want 0", valid_ppl); end
  endtask

  task automatic test_mul();
    int lat, bcy;
    logic [2:0]  f3 [0:2];
    logic [31:0] av [0:2];
    logic [31:0] bv [0:2];
    logic [31:0] ev [0:2];
    run_op(mdu_instr(3'd0), 32'h200, 32'd7, 32'hFFFF_FFFD, 2'd1, lat, bcy);
    vec_cnt++; if (lat != XLEN + 2) begin err_cnt++; $display("FAIL mul_latency got %0d want %0d", lat, XLEN + 2); end
    vec_cnt++; if (bcy != XLEN + 2) begin err_cnt++; $display("FAIL mul_busy_cycles got %0d want %0d", bcy, XLEN + 2); end
    vec_cnt++; if (result_ppl !== 32'hFFFF_FFEB) begin err_cnt++; $display("FAIL mul_result got %h want ffffffeb", result_ppl); end
    vec_cnt++; if (ill_ppl !== 1'b0) begin err_cnt++; $display("FAIL mul_ill got %b want 0", ill_ppl); end
    vec_cnt++; if (pc_ppl !== 32'h200) begin err_cnt++; $display("FAIL mul_pc got %h want 200", pc_ppl); end
    vec_cnt++; if (instruction_ppl !== mdu_instr(3'd0)) begin err_cnt++; $display("FAIL mul_instr got %h want %h", instruction_ppl, mdu_instr(3'd0)); end
    vec_cnt++; if (rdata2_ppl !== 32'hFFFF_FFFD) begin err_cnt++; $display("FAIL mul_rs2 got %h want fffffffd", rdata2_ppl); end
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mul_busy_end got %b want 0", busy); end
    f3 = '{3'd3, 3'd1, 3'd2};
    av = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    bv = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    ev = '{32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      run_op(mdu_instr(f3[i]), 32'h204, av[i], bv[i], 2'd0, lat, bcy);
      vec_cnt++; if (result_ppl !== ev[i]) begin err_cnt++; $display("FAIL mulh_f3_%0d got %h want %h", f3[i], result_ppl, ev[i]); end
      vec_cnt++; if (lat != XLEN + 2) begin err_cnt++; $display("FAIL mulh_latency_%0d got %0d want %0d", f3[i], lat, XLEN + 2); end
    end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    int lat, bcy;
    logic [2:0]  f3 [0:7];
    logic [31:0] av [0:7];
    logic [31:0] bv [0:7];
    logic [31:0] ev [0:7];
    int          lv [0:7];
    f3 = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7};
    av = '{32'h8000_0000, 32'h8000_0000, 32'd10, 32'd10, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    bv = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd2, 32'd2, 32'd7, 32'd7};
    ev = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    lv = '{34, 34, 3, 3, 34, 34, 34, 34};
    for (int i = 0; i < 8; i++) begin
      run_op(mdu_instr(f3[i]), 32'h400, av[i], bv[i], 2'd0, lat, bcy);
      vec_cnt++; if (result_ppl !== ev[i]) begin err_cnt++; $display("FAIL div_row%0d_result got %h want %h", i, result_ppl, ev[i]); end
      vec_cnt++; if (lat != lv[i]) begin err_cnt++; $display("FAIL div_row%0d_latency got %0d want %0d", i, lat, lv[i]); end
      vec_cnt++; if (bcy != lv[i]) begin err_cnt++; $display("FAIL div_row%0d_busy got %0d want %0d", i, bcy, lv[i]); end
      vec_cnt++; if (ill_ppl !== 1'b0) begin err_cnt++; $display("FAIL div_row%0d_ill got %b want 0", i, ill_ppl); end
    end
  endtask
`else
  task automatic test_div_disabled();
    logic [2:0] f3 [0:1];
    f3 = '{3'd7, 3'd4};
    for (int i = 0; i < 2; i++) begin
      drive(mdu_instr(f3[i]), 32'h500, 32'd10, 32'd3, 32'h55, 2'd0);
      #1;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL nodiv_busy_%0d got %b want 0", f3[i], busy); end
      tick();
      valid_in = 1'b0;
      vec_cnt++; if (valid_ppl !== 1'b1) begin err_cnt++; $display("FAIL nodiv_valid_%0d got %b want 1", f3[i], valid_ppl); end
      vec_cnt++; if (ill_ppl !== 1'b1) begin err_cnt++; $display("FAIL nodiv_ill_%0d got %b want 1", f3[i], ill_ppl); end
      vec_cnt++; if (result_ppl !== 32'h0) begin err_cnt++; $display("FAIL nodiv_result_%0d got %h want 0", f3[i], result_ppl); end
      #1;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL nodiv_busy_after_%0d got %b want 0", f3[i], busy); end
      tick();
    end
  endtask
`endif

  task automatic test_flush();
    int seen;
    drive(mdu_instr(3'd0), 32'h300, 32'd5, 32'd6, 32'h0, 2'd0);
    tick();
    valid_in = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL flush_busy got %b want 0", busy); end
    vec_cnt++; if (valid_ppl !== 1'b0) begin err_cnt++; $display("FAIL flush_valid got %b want 0", valid_ppl); end
    vec_cnt++; if (ill_ppl !== 1'b0) begin err_cnt++; $display("FAIL flush_ill got %b want 0", ill_ppl); end
    vec_cnt++; if (instruction_ppl !== 32'h0000_0013) begin err_cnt++; $display("FAIL flush_instr got %h want 00000013", instruction_ppl); end
    seen = 0;
    repeat (40) begin
      tick();
      if (valid_ppl || busy) seen++;
    end
    vec_cnt++; if (seen != 0) begin err_cnt++; $display("FAIL flush_ghost got %0d active cycles want 0", seen); end
    drive(ADD_X3, 32'h304, 32'd1, 32'd2, 32'h1234, 2'd0);
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL post_flush_busy got %b want 0", busy); end
    tick();
    valid_in = 1'b0;
    vec_cnt++; if (valid_ppl !== 1'b1) begin err_cnt++; $display("FAIL post_flush_valid got %b want 1", valid_ppl); end
    vec_cnt++; if (result_ppl !== 32'h1234) begin err_cnt++; $display("FAIL post_flush_result got %h want 1234", result_ppl); end
    vec_cnt++; if (instruction_ppl !== ADD_X3) begin err_cnt++; $display("FAIL post_flush_instr got %h want %h", instruction_ppl, ADD_X3); end
    tick();
  endtask

  task automatic test_stall_done();
    drive(ADDI_X3, 32'h600, 32'd0, 32'd0, 32'hABC, 2'd0);
    tick();
    drive(mdu_instr(3'd0), 32'h604, 32'd6, 32'd7, 32'h0, 2'd0);
    tick();
    valid_in = 1'b0;
    repeat (XLEN) tick();
    vec_cnt++; if (fsm_state !== ST_DONE) begin err_cnt++; $display("FAIL stall_reach_done got %0d want %0d", fsm_state, ST_DONE); end
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL stall_busy_%0d got %b want 1", i, busy); end
      tick();
      vec_cnt++; if (valid_ppl !== 1'b0) begin err_cnt++; $display("FAIL stall_valid_%0d got %b want 0", i, valid_ppl); end
      vec_cnt++; if (result_ppl !== 32'hABC) begin err_cnt++; $display("FAIL stall_hold_%0d got %h want abc", i, result_ppl); end
    end
    stall_in = 1'b0;
    #1;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL unstall_busy got %b want 1", busy); end
    tick();
    vec_cnt++; if (valid_ppl !== 1'b1) begin err_cnt++; $display("FAIL unstall_valid got %b want 1", valid_ppl); end
    vec_cnt++; if (result_ppl !== 32'd42) begin err_cnt++; $display("FAIL unstall_result got %h want 2a", result_ppl); end
    vec_cnt++; if (pc_ppl !== 32'h604) begin err_cnt++; $display("FAIL unstall_pc got %h want 604", pc_ppl); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL unstall_busy_end got %b want 0", busy); end
  endtask

  task automatic test_stall_idle();
    drive(ADDI_X3, 32'h700, 32'd0, 32'd0, 32'h11, 2'd0);
    tick();
    stall_in = 1'b1;
    drive(mdu_instr(3'd0), 32'h704, 32'd2, 32'd3, 32'h0, 2'd0);
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL stall_idle_busy got %b want 0", busy); end
    tick();
    vec_cnt++; if (fsm_state !== ST_IDLE) begin err_cnt++; $display("FAIL stall_idle_state got %0d want %0d", fsm_state, ST_IDLE); end
    drive(ADD_X3, 32'h708, 32'd0, 32'd0, 32'h99, 2'd0);
    tick();
    vec_cnt++; if (result_ppl !== 32'h11) begin err_cnt++; $display("FAIL stall_idle_result got %h want 11", result_ppl); end
    vec_cnt++; if (pc_ppl !== 32'h700) begin err_cnt++; $display("FAIL stall_idle_pc got %h want 700", pc_ppl); end
    vec_cnt++; if (valid_ppl !== 1'b1) begin err_cnt++; $display("FAIL stall_idle_valid got %b want 1", valid_ppl); end
    stall_in = 1'b0;
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [0:3];
    logic [31:0] exp_v;
    vals = '{32'h1, 32'hCAFE_0001, 32'h0, 32'h7FFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      drive(ADD_X3, 32'h800 + 32'(4 * i), 32'd0, 32'd0, vals[i], 2'd0);
      exp_q.push_back(vals[i]);
      tick();
      exp_v = exp_q.pop_front();
      vec_cnt++; if (result_ppl !== exp_v) begin err_cnt++; $display("FAIL b2b_result_%0d got %h want %h", i, result_ppl, exp_v); end
      vec_cnt++; if (pc_ppl !== 32'h800 + 32'(4 * i)) begin err_cnt++; $display("FAIL b2b_pc_%0d got %h want %h", i, pc_ppl, 32'h800 + 32'(4 * i)); end
    end
    valid_in = 1'b0;
    tick();
    vec_cnt++; if (valid_ppl !== 1'b0) begin err_cnt++; $display("FAIL b2b_drain_valid got %b want 0", valid_ppl); end
  endtask

  task automatic test_reset_mid();
    int seen;
    drive(ADDI_X3, 32'h900, 32'd0, 32'd0, 32'h66, 2'd0);
    tick();
    drive(mdu_instr(3'd0), 32'h904, 32'd3, 32'd3, 32'h0, 2'd0);
    tick();
    valid_in = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy got %b want 0", busy); end
    vec_cnt++; if (result_ppl !== 32'h0) begin err_cnt++; $display("FAIL rstmid_result got %h want 0", result_ppl); end
    vec_cnt++; if (instruction_ppl !== 32'h0000_0013) begin err_cnt++; $display("FAIL rstmid_instr got %h want 00000013", instruction_ppl); end
    seen = 0;
    repeat (40) begin
      tick();
      if (valid_ppl) seen++;
    end
    vec_cnt++; if (seen != 0) begin err_cnt++; $display("FAIL rstmid_ghost got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_flush();
    test_stall_done();
    test_stall_idle();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
